// File: rtl/pgm_pkg.sv
// Shared constants and helpers for the PGM 68k<->Z80 sound mailbox.
package pgm_pkg;

   localparam int DEF_NUM_CH = 3;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_DATA_W = 8;

   // A single channel still needs a one-bit select so the port never collapses to zero width.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pgm_mbox_fifo.sv
// Single-channel command FIFO: DEPTH x DATA_W with push/pop, occupancy count and flags.
module pgm_mbox_fifo
   import pgm_pkg::*;
#(
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int PW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output logic [PW:0]       count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_push = push_i & (~full_o | do_pop);

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/pgm_sound_mailbox.sv
// 68k->Z80 command mailbox: NUM_CH command FIFOs, per-channel Z80 reply latches,
// overflow flags and a registered active-low Z80 interrupt request.
module pgm_sound_mailbox
   import pgm_pkg::*;
#(
   parameter  int NUM_CH = DEF_NUM_CH,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int CHW    = ch_w(NUM_CH)
) (
   input  logic              fixed_20m_clk,
   input  logic              reset,
   input  logic              main_wr,
   input  logic [CHW-1:0]    main_ch,
   input  logic [DATA_W-1:0] main_wdata,
   input  logic              main_rd,
   output logic [DATA_W-1:0] main_rdata,
   input  logic              snd_rd,
   input  logic [CHW-1:0]    snd_ch,
   output logic [DATA_W-1:0] snd_rdata,
   input  logic              snd_wr,
   input  logic [DATA_W-1:0] snd_wdata,
   input  logic [NUM_CH-1:0] irq_en,
   input  logic              ovf_clr,
   output logic [NUM_CH-1:0] ch_pending,
   output logic [NUM_CH-1:0] ch_full,
   output logic [NUM_CH-1:0] ch_ovf,
   output logic [NUM_CH-1:0] reply_valid,
   output logic              snd_int_n
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] head    [NUM_CH];
   logic [PW:0]       count   [NUM_CH];
   logic [DATA_W-1:0] reply_q [NUM_CH];
   logic [DATA_W-1:0] reply_d [NUM_CH];

   logic [NUM_CH-1:0] main_sel, snd_sel, push, pop, pop_ok, ovf_ev, empty, full;
   logic [NUM_CH-1:0] ch_ovf_q, ch_ovf_d;
   logic [NUM_CH-1:0] reply_valid_q, reply_valid_d;
   logic [DATA_W-1:0] main_rdata_q, main_rdata_d;
   logic [DATA_W-1:0] snd_rdata_q, snd_rdata_d;
   logic              snd_int_n_q;

   // Out-of-range selects match no channel, so their strobes are dropped entirely.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [CHW-1:0] IDX = CHW'(c);

      assign main_sel[c] = (main_ch == IDX);
      assign snd_sel[c]  = (snd_ch == IDX);
      assign push[c]     = main_wr & main_sel[c];
      assign pop[c]      = snd_rd & snd_sel[c];

      pgm_mbox_fifo #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_fifo (
         .clk_i   (fixed_20m_clk),
         .reset_i (reset),
         .push_i  (push[c]),
         .pop_i   (pop[c]),
         .wdata_i (main_wdata),
         .head_o  (head[c]),
         .count_o (count[c]),
         .full_o  (full[c]),
         .empty_o (empty[c])
      );

      assign pop_ok[c] = pop[c] & (count[c] != '0);
      assign ovf_ev[c] = push[c] & full[c] & ~pop[c];
   end

   assign ch_pending = ~empty;
   assign ch_full    = full;

   always_comb begin
      snd_rdata_d   = snd_rdata_q;
      main_rdata_d  = main_rdata_q;
      reply_d       = reply_q;
      reply_valid_d = reply_valid_q;
      ch_ovf_d      = (ch_ovf_q & ~{NUM_CH{ovf_clr}}) | ovf_ev;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pop_ok[c]) snd_rdata_d = head[c];
         if (main_rd && main_sel[c]) begin
            main_rdata_d     = reply_q[c];
            reply_valid_d[c] = 1'b0;
         end
         // A Z80 write in the same cycle as a 68k read keeps the reply marked unread.
         if (snd_wr && snd_sel[c]) begin
            reply_d[c]       = snd_wdata;
            reply_valid_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge fixed_20m_clk) begin
      if (reset) begin
         snd_rdata_q   <= '0;
         main_rdata_q  <= '0;
         reply_q       <= '{default: '0};
         reply_valid_q <= '0;
         ch_ovf_q      <= '0;
         snd_int_n_q   <= 1'b1;
      end else begin
         snd_rdata_q   <= snd_rdata_d;
         main_rdata_q  <= main_rdata_d;
         reply_q       <= reply_d;
         reply_valid_q <= reply_valid_d;
         ch_ovf_q      <= ch_ovf_d;
         snd_int_n_q   <= ~|(ch_pending & irq_en);
      end
   end

   assign snd_rdata   = snd_rdata_q;
   assign main_rdata  = main_rdata_q;
   assign reply_valid = reply_valid_q;
   assign ch_ovf      = ch_ovf_q;
   assign snd_int_n   = snd_int_n_q;

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Directed table-driven bench for pgm_sound_mailbox at default parameters.
module tb_pgm_sound_mailbox;

   logic       clk = 1'b0;
   logic       reset;
   logic       main_wr, main_rd, snd_rd, snd_wr, ovf_clr;
   logic [1:0] main_ch, snd_ch;
   logic [7:0] main_wdata, snd_wdata, main_rdata, snd_rdata;
   logic [2:0] irq_en, ch_pending, ch_full, ch_ovf, reply_valid;
   logic       snd_int_n;

   int checks   = 0;
   int failures = 0;

   always #25 clk = ~clk;

   pgm_sound_mailbox dut (
      .fixed_20m_clk (clk),
      .reset         (reset),
      .main_wr       (main_wr),
      .main_ch       (main_ch),
      .main_wdata    (main_wdata),
      .main_rd       (main_rd),
      .main_rdata    (main_rdata),
      .snd_rd        (snd_rd),
      .snd_ch        (snd_ch),
      .snd_rdata     (snd_rdata),
      .snd_wr        (snd_wr),
      .snd_wdata     (snd_wdata),
      .irq_en        (irq_en),
      .ovf_clr       (ovf_clr),
      .ch_pending    (ch_pending),
      .ch_full       (ch_full),
      .ch_ovf        (ch_ovf),
      .reply_valid   (reply_valid),
      .snd_int_n     (snd_int_n)
   );

   typedef struct {
      string      name;
      logic       mw;
      logic [1:0] mch;
      logic [7:0] md;
      logic       mr;
      logic       sr;
      logic [1:0] sch;
      logic       sw;
      logic [7:0] sd;
      logic       clr;
      logic [7:0] e_srd;
      logic [7:0] e_mrd;
      logic [2:0] e_pend;
      logic [2:0] e_full;
      logic [2:0] e_ovf;
      logic [2:0] e_rv;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(string nm, logic mw, logic [1:0] mch, logic [7:0] md, logic mr,
                              logic sr, logic [1:0] sch, logic sw, logic [7:0] sd, logic clr,
                              logic [7:0] e_srd, logic [7:0] e_mrd, logic [2:0] e_pend,
                              logic [2:0] e_full, logic [2:0] e_ovf, logic [2:0] e_rv);
      vec_t r;
      r.name = nm; r.mw = mw; r.mch = mch; r.md = md; r.mr = mr; r.sr = sr; r.sch = sch;
      r.sw = sw; r.sd = sd; r.clr = clr; r.e_srd = e_srd; r.e_mrd = e_mrd; r.e_pend = e_pend;
      r.e_full = e_full; r.e_ovf = e_ovf; r.e_rv = e_rv;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      main_wr = 0; main_rd = 0; snd_rd = 0; snd_wr = 0; ovf_clr = 0;
      main_ch = 0; snd_ch = 0; main_wdata = 0; snd_wdata = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   initial begin
      // mw mch md  mr sr sch sw sd clr | srd mrd pend full ovf rv
      tbl.push_back(v("push11",   1,1,8'h11,0, 0,0,0,8'h00,0, 8'h00,8'h00,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("push22",   1,1,8'h22,0, 0,0,0,8'h00,0, 8'h00,8'h00,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("push33",   1,1,8'h33,0, 0,0,0,8'h00,0, 8'h00,8'h00,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop11",    0,0,8'h00,0, 1,1,0,8'h00,0, 8'h11,8'h00,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop22",    0,0,8'h00,0, 1,1,0,8'h00,0, 8'h22,8'h00,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop33",    0,0,8'h00,0, 1,1,0,8'h00,0, 8'h33,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop_empty",0,0,8'h00,0, 1,1,0,8'h00,0, 8'h33,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("pushA0",   1,0,8'hA0,0, 0,0,0,8'h00,0, 8'h33,8'h00,3'b001,3'b000,3'b000,3'b000));
      tbl.push_back(v("pushA1",   1,0,8'hA1,0, 0,0,0,8'h00,0, 8'h33,8'h00,3'b001,3'b000,3'b000,3'b000));
      tbl.push_back(v("pushA2",   1,0,8'hA2,0, 0,0,0,8'h00,0, 8'h33,8'h00,3'b001,3'b000,3'b000,3'b000));
      tbl.push_back(v("pushA3",   1,0,8'hA3,0, 0,0,0,8'h00,0, 8'h33,8'h00,3'b001,3'b001,3'b000,3'b000));
      tbl.push_back(v("pushA4ovf",1,0,8'hA4,0, 0,0,0,8'h00,0, 8'h33,8'h00,3'b001,3'b001,3'b001,3'b000));
      tbl.push_back(v("popA0",    0,0,8'h00,0, 1,0,0,8'h00,0, 8'hA0,8'h00,3'b001,3'b000,3'b001,3'b000));
      tbl.push_back(v("popA1",    0,0,8'h00,0, 1,0,0,8'h00,0, 8'hA1,8'h00,3'b001,3'b000,3'b001,3'b000));
      tbl.push_back(v("popA2",    0,0,8'h00,0, 1,0,0,8'h00,0, 8'hA2,8'h00,3'b001,3'b000,3'b001,3'b000));
      tbl.push_back(v("popA3",    0,0,8'h00,0, 1,0,0,8'h00,0, 8'hA3,8'h00,3'b000,3'b000,3'b001,3'b000));
      tbl.push_back(v("ovf_clr",  0,0,8'h00,0, 0,0,0,8'h00,1, 8'hA3,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("push61",   1,2,8'h61,0, 0,0,0,8'h00,0, 8'hA3,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("push62",   1,2,8'h62,0, 0,0,0,8'h00,0, 8'hA3,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("push63",   1,2,8'h63,0, 0,0,0,8'h00,0, 8'hA3,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("push64",   1,2,8'h64,0, 0,0,0,8'h00,0, 8'hA3,8'h00,3'b100,3'b100,3'b000,3'b000));
      tbl.push_back(v("full_pp",  1,2,8'h55,0, 1,2,0,8'h00,0, 8'h61,8'h00,3'b100,3'b100,3'b000,3'b000));
      tbl.push_back(v("pop62",    0,0,8'h00,0, 1,2,0,8'h00,0, 8'h62,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop63",    0,0,8'h00,0, 1,2,0,8'h00,0, 8'h63,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop64",    0,0,8'h00,0, 1,2,0,8'h00,0, 8'h64,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop55",    0,0,8'h00,0, 1,2,0,8'h00,0, 8'h55,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("empty_pp", 1,2,8'h77,0, 1,2,0,8'h00,0, 8'h55,8'h00,3'b100,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop77",    0,0,8'h00,0, 1,2,0,8'h00,0, 8'h77,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("pop_empty2",0,0,8'h00,0,1,2,0,8'h00,0, 8'h77,8'h00,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("reply7E",  0,0,8'h00,0, 0,2,1,8'h7E,0, 8'h77,8'h00,3'b000,3'b000,3'b000,3'b100));
      tbl.push_back(v("read7E",   0,2,8'h00,1, 0,0,0,8'h00,0, 8'h77,8'h7E,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("wr7F_rd",  0,2,8'h00,1, 0,2,1,8'h7F,0, 8'h77,8'h7E,3'b000,3'b000,3'b000,3'b100));
      tbl.push_back(v("read7F",   0,2,8'h00,1, 0,0,0,8'h00,0, 8'h77,8'h7F,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("oor_wr",   1,3,8'h99,0, 0,3,1,8'h88,0, 8'h77,8'h7F,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("oor_rd",   0,3,8'h00,1, 1,3,0,8'h00,0, 8'h77,8'h7F,3'b000,3'b000,3'b000,3'b000));
      tbl.push_back(v("push01",   1,1,8'h01,0, 0,0,0,8'h00,0, 8'h77,8'h7F,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("push02",   1,1,8'h02,0, 0,0,0,8'h00,0, 8'h77,8'h7F,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("push03",   1,1,8'h03,0, 0,0,0,8'h00,0, 8'h77,8'h7F,3'b010,3'b000,3'b000,3'b000));
      tbl.push_back(v("push04",   1,1,8'h04,0, 0,0,0,8'h00,0, 8'h77,8'h7F,3'b010,3'b010,3'b000,3'b000));
      tbl.push_back(v("ovf_vs_clr",1,1,8'h05,0,0,0,0,8'h00,1, 8'h77,8'h7F,3'b010,3'b010,3'b010,3'b000));
      tbl.push_back(v("clr_only", 0,0,8'h00,0, 0,0,0,8'h00,1, 8'h77,8'h7F,3'b010,3'b010,3'b000,3'b000));
      tbl.push_back(v("cross_ch", 1,0,8'hC0,0, 1,1,0,8'h00,0, 8'h01,8'h7F,3'b011,3'b000,3'b000,3'b000));

      idle_inputs();
      irq_en = 3'b000;
      reset  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_snd_rdata",  32'(snd_rdata),   32'h00);
      check("rst_main_rdata", 32'(main_rdata),  32'h00);
      check("rst_pending",    32'(ch_pending),  32'h0);
      check("rst_full",       32'(ch_full),     32'h0);
      check("rst_ovf",        32'(ch_ovf),      32'h0);
      check("rst_reply_vld",  32'(reply_valid), 32'h0);
      check("rst_int_n",      32'(snd_int_n),   32'h1);
      reset = 1'b0;

      foreach (tbl[i]) begin
         main_wr = tbl[i].mw; main_ch = tbl[i].mch; main_wdata = tbl[i].md; main_rd = tbl[i].mr;
         snd_rd = tbl[i].sr; snd_ch = tbl[i].sch; snd_wr = tbl[i].sw; snd_wdata = tbl[i].sd;
         ovf_clr = tbl[i].clr;
         tick();
         check({tbl[i].name, ".snd_rdata"},  32'(snd_rdata),   32'(tbl[i].e_srd));
         check({tbl[i].name, ".main_rdata"}, 32'(main_rdata),  32'(tbl[i].e_mrd));
         check({tbl[i].name, ".pending"},    32'(ch_pending),  32'(tbl[i].e_pend));
         check({tbl[i].name, ".full"},       32'(ch_full),     32'(tbl[i].e_full));
         check({tbl[i].name, ".ovf"},        32'(ch_ovf),      32'(tbl[i].e_ovf));
         check({tbl[i].name, ".reply_vld"},  32'(reply_valid), 32'(tbl[i].e_rv));
         check({tbl[i].name, ".int_n"},      32'(snd_int_n),   32'h1);
      end

      // Mid-operation reset with a simultaneous push: queues are discarded, push is ignored.
      reset = 1'b1; main_wr = 1'b1; main_ch = 2'd0; main_wdata = 8'hEE;
      tick();
      reset = 1'b0;
      check("mid_rst_pending",  32'(ch_pending),  32'h0);
      check("mid_rst_full",     32'(ch_full),     32'h0);
      check("mid_rst_snd_rd",   32'(snd_rdata),   32'h00);
      check("mid_rst_main_rd",  32'(main_rdata),  32'h00);
      check("mid_rst_int_n",    32'(snd_int_n),   32'h1);
      snd_rd = 1'b1; snd_ch = 2'd1;
      tick();
      check("post_rst_pop",     32'(snd_rdata),   32'h00);
      check("post_rst_pending", 32'(ch_pending),  32'h0);

      // Interrupt masking and its one-cycle lag behind ch_pending.
      irq_en = 3'b010;
      main_wr = 1'b1; main_ch = 2'd0; main_wdata = 8'h10;
      tick();
      check("irq_ch0_push",     32'(snd_int_n),   32'h1);
      tick();
      check("irq_ch0_masked",   32'(snd_int_n),   32'h1);
      main_wr = 1'b1; main_ch = 2'd1; main_wdata = 8'h20;
      tick();
      check("irq_ch1_lag",      32'(snd_int_n),   32'h1);
      check("irq_ch1_pending",  32'(ch_pending),  32'h3);
      tick();
      check("irq_ch1_assert",   32'(snd_int_n),   32'h0);
      snd_rd = 1'b1; snd_ch = 2'd1;
      tick();
      check("irq_pop_data",     32'(snd_rdata),   32'h20);
      check("irq_pop_lag",      32'(snd_int_n),   32'h0);
      tick();
      check("irq_deassert",     32'(snd_int_n),   32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pgm_sound_mailbox.md
PGM_SOUND_MAILBOX -- requirements
Module: pgm_sound_mailbox

Interface
REQ-001 Parameter NUM_CH, default 3: number of 68k->Z80 command channels, 1..8.
REQ-002 Parameter DEPTH, default 4: entries per channel FIFO, power of two, 2..16.
REQ-003 Parameter DATA_W, default 8: command/reply data width.
REQ-004 fixed_20m_clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 main_wr  in  1  one-cycle strobe: push main_wdata into channel main_ch.
REQ-007 main_ch  in  CHW=max(1,clog2(NUM_CH))  channel select for main_wr/main_rd.
REQ-008 main_wdata  in  DATA_W  command byte from 68k.
REQ-009 main_rd  in  1  one-cycle strobe: read reply latch of main_ch.
REQ-010 main_rdata  out  DATA_W  reply data, registered.
REQ-011 snd_rd  in  1  one-cycle strobe: pop head of channel snd_ch.
REQ-012 snd_ch  in  CHW  channel select for snd_rd/snd_wr.
REQ-013 snd_rdata  out  DATA_W  popped command, registered.
REQ-014 snd_wr  in  1  one-cycle strobe: write snd_wdata to reply latch of snd_ch.
REQ-015 snd_wdata  in  DATA_W  reply byte from Z80.
REQ-016 irq_en  in  NUM_CH  per-channel enable of Z80 interrupt.
REQ-017 ovf_clr  in  1  one-cycle strobe: clear all overflow flags.
REQ-018 ch_pending  out  NUM_CH  channel FIFO non-empty.
REQ-019 ch_full  out  NUM_CH  channel FIFO holds DEPTH entries.
REQ-020 ch_ovf  out  NUM_CH  sticky: write attempted while full.
REQ-021 reply_valid  out  NUM_CH  reply latch written by Z80 and not yet read by 68k.
REQ-022 snd_int_n  out  1  active-low Z80 interrupt request, registered.

Function
REQ-023 Each channel: DEPTH-entry FIFO, read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH, count of clog2(DEPTH)+1 bits.
REQ-024 main_wr to non-full channel: entry stored at write pointer; count +1 on the next edge.
REQ-025 main_wr to full channel without simultaneous pop there: data dropped, pointers unchanged, ch_ovf[ch] set.
REQ-026 snd_rd on non-empty channel: snd_rdata = head entry on the following edge (latency 1); read pointer advances, count -1.
REQ-027 snd_rd on empty channel: snd_rdata holds previous value, no pointer change, no flag.
REQ-028 Same-cycle push and pop on same channel, non-empty: both performed, count unchanged; full case: both performed, no overflow.
REQ-029 Same-cycle push and pop on same empty channel: pop ignored (REQ-027), push stored, count becomes 1.
REQ-030 Push and pop on different channels in one cycle are independent.
REQ-031 snd_wr: reply latch[snd_ch] <= snd_wdata, reply_valid set; overwriting an unread reply permitted.
REQ-032 main_rd: main_rdata <= reply latch[main_ch] next edge; reply_valid[main_ch] cleared, unless snd_wr targets the same channel that cycle, in which case new data wins and reply_valid stays set; main_rdata returns old value.
REQ-033 ovf_clr clears ch_ovf; if an overflow occurs the same cycle, that flag is set (set wins).
REQ-034 ch_pending/ch_full combinational from counts; snd_int_n <= ~|(ch_pending & irq_en) each edge (one-cycle delay).
REQ-035 main_ch/snd_ch >= NUM_CH: strobe ignored entirely; read data holds.

Reset
REQ-036 On reset: pointers, counts, ch_ovf, reply_valid = 0; main_rdata, snd_rdata, reply latches = 0; snd_int_n = 1; FIFO storage contents not cleared.
REQ-037 Reset overrides any simultaneous strobe; mid-operation reset discards all queued commands.

Structure
REQ-038 Shared package pgm_pkg holds default NUM_CH/DEPTH/DATA_W constants and the channel-index width function.
REQ-039 One sub-module pgm_mbox_fifo (single channel, DEPTH x DATA_W, push/pop/count/full/empty), instantiated NUM_CH times by generate.

Verification
REQ-040 Defaults: push 0x11,0x22,0x33 on ch1, pop x3 -> snd_rdata 0x11,0x22,0x33, each one cycle after pop; ch_pending[1] falls after third pop.
REQ-041 Push 5 bytes 0xA0..0xA4 into ch0 (DEPTH=4) -> ch_full[0]=1 after fourth, ch_ovf[0]=1, pops return 0xA0..0xA3; ovf_clr -> ch_ovf[0]=0.
REQ-042 Full ch2: simultaneous push 0x55 and pop -> pop returns oldest, count stays 4, ch_ovf[2]=0; empty ch2: simultaneous push/pop -> snd_rdata unchanged, count 1.
REQ-043 irq_en=3'b010, push to ch0 -> snd_int_n stays 1; push to ch1 -> snd_int_n=0 one cycle later; pop ch1 empty -> snd_int_n=1.
REQ-044 snd_wr 0x7E ch2 -> reply_valid[2]=1; main_rd ch2 -> main_rdata=0x7E, reply_valid[2]=0; same-cycle snd_wr 0x7F and main_rd -> main_rdata=0x7E, reply_valid[2]=1.
REQ-045 Queue 2 entries, assert reset 1 cycle -> all counts 0, snd_int_n=1, snd_rdata=0, ch_pending=0.
